// File: rtl/ysyx_23060124_wb_arbiter.sv
// Writeback arbiter: one holding slot each for EXU and LSU results, round-robin
// grant into a registered register-file write port, plus commit pulse and retire counter.
module ysyx_23060124_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [4:0]       exu_rd,
  input  logic             exu_rd_wen,
  input  logic [XLEN-1:0]  exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic             lsu_rd_wen,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             wen,
  output logic [4:0]       waddr,
  output logic [XLEN-1:0]  wdata,
  output logic             commit,
  output logic [CNT_W-1:0] retire_cnt
);

  logic            exu_slot_v_r;
  logic [4:0]      exu_slot_rd_r;
  logic            exu_slot_wen_r;
  logic [XLEN-1:0] exu_slot_data_r;
  logic            lsu_slot_v_r;
  logic [4:0]      lsu_slot_rd_r;
  logic            lsu_slot_wen_r;
  logic [XLEN-1:0] lsu_slot_data_r;

  logic            rr_last_r;  // 0 = EXU granted last, 1 = LSU
  logic            grant_exu_s;
  logic            grant_lsu_s;
  logic [4:0]      sel_rd_s;
  logic            sel_wen_s;
  logic [XLEN-1:0] sel_data_s;

  logic             wen_r;
  logic [4:0]       waddr_r;
  logic [XLEN-1:0]  wdata_r;
  logic             commit_r;
  logic [CNT_W-1:0] retire_cnt_r;

  // Grant arbitration from registered slot state only.
  always_comb begin
    grant_exu_s = 1'b0;
    grant_lsu_s = 1'b0;
    case ({exu_slot_v_r, lsu_slot_v_r})
      2'b10: grant_exu_s = 1'b1;
      2'b01: grant_lsu_s = 1'b1;
      2'b11: begin
        if (rr_last_r) begin
          grant_exu_s = 1'b1;
        end else begin
          grant_lsu_s = 1'b1;
        end
      end
      default: begin
        grant_exu_s = 1'b0;
        grant_lsu_s = 1'b0;
      end
    endcase
  end

  // Payload mux for the granted slot.
  always_comb begin
    sel_rd_s   = exu_slot_rd_r;
    sel_wen_s  = exu_slot_wen_r;
    sel_data_s = exu_slot_data_r;
    if (grant_lsu_s) begin
      sel_rd_s   = lsu_slot_rd_r;
      sel_wen_s  = lsu_slot_wen_r;
      sel_data_s = lsu_slot_data_r;
    end else begin
      sel_rd_s   = exu_slot_rd_r;
      sel_wen_s  = exu_slot_wen_r;
      sel_data_s = exu_slot_data_r;
    end
  end

  // A slot can accept when empty or when it drains on this same edge.
  assign exu_ready = ~exu_slot_v_r | grant_exu_s;
  assign lsu_ready = ~lsu_slot_v_r | grant_lsu_s;

  // EXU holding slot: a same-edge refill takes priority over the drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exu_slot_v_r    <= 1'b0;
      exu_slot_rd_r   <= 5'd0;
      exu_slot_wen_r  <= 1'b0;
      exu_slot_data_r <= {XLEN{1'b0}};
    end else if (exu_valid && exu_ready) begin
      exu_slot_v_r    <= 1'b1;
      exu_slot_rd_r   <= exu_rd;
      exu_slot_wen_r  <= exu_rd_wen;
      exu_slot_data_r <= exu_data;
    end else if (grant_exu_s) begin
      exu_slot_v_r    <= 1'b0;
    end
  end

  // LSU holding slot, same policy as EXU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lsu_slot_v_r    <= 1'b0;
      lsu_slot_rd_r   <= 5'd0;
      lsu_slot_wen_r  <= 1'b0;
      lsu_slot_data_r <= {XLEN{1'b0}};
    end else if (lsu_valid && lsu_ready) begin
      lsu_slot_v_r    <= 1'b1;
      lsu_slot_rd_r   <= lsu_rd;
      lsu_slot_wen_r  <= lsu_rd_wen;
      lsu_slot_data_r <= lsu_data;
    end else if (grant_lsu_s) begin
      lsu_slot_v_r    <= 1'b0;
    end
  end

  // Round-robin pointer; reset value makes the first tie go to EXU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_last_r <= 1'b1;
    end else if (grant_exu_s) begin
      rr_last_r <= 1'b0;
    end else if (grant_lsu_s) begin
      rr_last_r <= 1'b1;
    end
  end

  // Register-file write port and commit pulse; x0 and no-write results still commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen_r    <= 1'b0;
      waddr_r  <= 5'd0;
      wdata_r  <= {XLEN{1'b0}};
      commit_r <= 1'b0;
    end else if (grant_exu_s || grant_lsu_s) begin
      wen_r    <= sel_wen_s && (sel_rd_s != 5'd0);
      waddr_r  <= sel_rd_s;
      wdata_r  <= sel_data_s;
      commit_r <= 1'b1;
    end else begin
      wen_r    <= 1'b0;
      commit_r <= 1'b0;
    end
  end

  // Retire counter follows the registered commit pulse, wrapping naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (commit_r) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wen        = wen_r;
  assign waddr      = waddr_r;
  assign wdata      = wdata_r;
  assign commit     = commit_r;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: doc/ysyx_23060124_wb_arbiter.md
# ysyx_23060124_wb_arbiter

Writeback arbiter between the execute-side producers and the register-file write port. It accepts completed results from the ALU path (EXU) and the load path (LSU) over valid/ready handshakes and buffers one result per source. It grants one buffered result per cycle with round-robin fairness and drives a registered `wen`/`waddr`/`wdata` triple into the register file, which clears the scoreboard bit for that destination. It also emits a per-instruction commit pulse and a retire counter.

## Interface
Parameters:
- `XLEN`, 32, data width of results and write port
- `CNT_W`, 32, width of the retire counter

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `exu_valid`  in  1  EXU result present
- `exu_ready`  out  1  arbiter can take EXU result this cycle
- `exu_rd`  in  5  EXU destination register index
- `exu_rd_wen`  in  1  EXU instruction writes rd
- `exu_data`  in  XLEN  EXU result
- `lsu_valid`  in  1  LSU result present
- `lsu_ready`  out  1  arbiter can take LSU result this cycle
- `lsu_rd`  in  5  LSU destination register index
- `lsu_rd_wen`  in  1  LSU instruction writes rd
- `lsu_data`  in  XLEN  LSU load data
- `wen`  out  1  register-file write enable (registered)
- `waddr`  out  5  register-file write index (registered)
- `wdata`  out  XLEN  register-file write data (registered)
- `commit`  out  1  one-cycle pulse per retired instruction (registered)
- `retire_cnt`  out  CNT_W  count of retired instructions

## Operation
- Per source, one holding slot: `slot_v`, `slot_rd`, `slot_wen`, `slot_data`.
- Handshake: transfer when `x_valid && x_ready` at a rising edge. Slot captures rd/rd_wen/data at that edge.
- `x_ready = !slot_v_x || grant_x`. Grant depends only on registered state, so there is no combinational path from `x_valid` to `x_ready`.
- Grant, combinational from slot state and `rr_last` (0 = EXU, 1 = LSU):
  - Only EXU slot valid: grant EXU.
  - Only LSU slot valid: grant LSU.
  - Both valid: grant the source not equal to `rr_last`.
  - Neither valid: no grant.
- On a granted edge:
  - The granted slot clears, unless it is refilled by a same-edge handshake, in which case it holds the new entry.
  - `rr_last` is set to the granted source.
  - `commit <= 1`.
  - `wen <= slot_wen && (slot_rd != 0)`.
  - `waddr <= slot_rd`, `wdata <= slot_data`.
- Without a grant: `wen <= 0` and `commit <= 0`; `waddr` and `wdata` hold.
- Instructions with `rd_wen = 0` or `rd = 0` still commit (`commit = 1`, `wen = 0`).
- `retire_cnt` increments by 1 on every edge where `commit` is registered high. It wraps modulo 2^CNT_W.
- `waddr` is passed as the full 5 bits, unmodified. Index truncation is the register file's concern.
- Order is preserved within one source. No order is guaranteed between sources; the issue-side scoreboard prevents same-rd conflicts.

## Timing
- Reset (`reset` low, asynchronous):
  - All `slot_v` = 0, `rr_last` = 1.
  - `wen` = 0, `waddr` = 0, `wdata` = 0, `commit` = 0, `retire_cnt` = 0.
  - Hence `exu_ready` = `lsu_ready` = 1 while reset is held and immediately after release.
- Latency: handshake at edge T, grant evaluated during cycle T..T+1, `wen`/`commit` high in the cycle following edge T+1. That is 2 edges from acceptance to write visible.
- Throughput:
  - A single streaming source sustains 1 result per cycle.
  - With both sources saturated, each gets 1 per 2 cycles, strictly alternating.
  - First tie after reset goes to EXU.
- A source whose slot is full and not granted holds `x_ready = 0` until granted. The producer must keep `x_valid` and its payload stable while `x_ready = 0`.
- Reset asserted mid-operation discards both slots and any pending write. `wen` drops asynchronously, with no partial write.
- Outputs change only on clock edges or asynchronous reset.

## Test plan
- Reset release, idle: after reset, `exu_ready = lsu_ready = 1`, `wen = 0`, `commit = 0`, `retire_cnt = 0`; stays idle with no valids.
- Single EXU write: `exu_rd = 5`, `exu_data = 0xDEADBEEF`, `exu_rd_wen = 1` accepted at edge T -> cycle after T+1 shows `wen = 1`, `waddr = 5`, `wdata = 0xDEADBEEF`, `commit = 1`; next cycle `wen = 0`, `retire_cnt = 1`.
- x0 and no-write retire: LSU `rd = 0`, `data = 0x1234` with `rd_wen = 1`, then EXU `rd = 7` with `rd_wen = 0` -> two commit pulses, `wen = 0` both times, `retire_cnt = 2`.
- Contention: both sources stream 4 results each (EXU `rd` 1..4, LSU `rd` 9..12) -> writes alternate 1, 9, 2, 10, 3, 11, 4, 12; `exu_ready` and `lsu_ready` toggle low on alternate cycles; `retire_cnt = 8`.
- Single-source back-to-back: EXU valid for 6 consecutive cycles with `rd` 1..6 -> `exu_ready` stays 1, `wen` high for 6 consecutive cycles in order.
- Reset mid-flight: both slots full, `reset` pulled low between edges -> `wen`, `commit` and `retire_cnt` go to 0 immediately; after release no stale write appears.
